wb_arbiter: RTL and testbench

Writeback arbiter that shares the register file's single write port (`wen`, `regW_sel`, `regW_i`) between two producers, such as the ALU and the load unit. Each producer hands over results through a valid/ready handshake into its own one-entry holding buffer. The arbiter retires one buffered write per cycle, oldest first, and tells the decode stage when a read selector hits a write that has not landed yet.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_arbiter_if.sv | 36 +++
 rtl/wb_slot.sv | 43 ++++
 rtl/wb_arbiter.sv | 107 ++++++++++
 tb/tb_wb_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter slice.
//   NUM_WB_REQ : number of producers sharing the regfile write port
//   addrWidth  : register-select width for a given register count
//   wb_req_t   : one buffered write (select + data) at the default widths
package wb_pkg;

  localparam int NUM_WB_REQ       = 2;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_REG_COUNT    = 32;

  function automatic int addrWidth(input int regCount);
    return (regCount > 1) ? $clog2(regCount) : 1;
  endfunction

  localparam int DEF_ADDR_WIDTH = addrWidth(DEF_REG_COUNT);

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] sel;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the producers/decode stage and the writeback arbiter.
//   req_valid/req_ready/req_sel/req_data : per-producer write handshake
//   wen/regW_sel/regW_i                  : regfile write port
//   regA_sel/regB_sel                    : snooped decode read selectors
//   hazard_a/hazard_b                    : pending-write hits on A/B
// Modports: master = producers + decode, slave = arbiter.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic [NUM_WB_REQ-1:0]                 req_valid;
  logic [NUM_WB_REQ-1:0]                 req_ready;
  logic [NUM_WB_REQ-1:0][ADDR_WIDTH-1:0] req_sel;
  logic [NUM_WB_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic                                  wen;
  logic [ADDR_WIDTH-1:0]                 regW_sel;
  logic [DATA_WIDTH-1:0]                 regW_i;
  logic [ADDR_WIDTH-1:0]                 regA_sel;
  logic [ADDR_WIDTH-1:0]                 regB_sel;
  logic                                  hazard_a;
  logic                                  hazard_b;

  modport master (
    output req_valid, req_sel, req_data, regA_sel, regB_sel,
    input  req_ready, wen, regW_sel, regW_i, hazard_a, hazard_b
  );

  modport slave (
    input  req_valid, req_sel, req_data, regA_sel, regB_sel,
    output req_ready, wen, regW_sel, regW_i, hazard_a, hazard_b
  );

endinterface

// File: rtl/wb_slot.sv
// One-entry holding buffer for a single writeback producer.
//   inValid/inSel/inData : producer request
//   grant                : arbiter is retiring this entry this cycle
//   ready                : producer may hand over (empty, or draining now)
//   load                 : a non-x0 write is captured at this edge
//   bufV/bufSel/bufData  : buffered entry
module wb_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  input  logic [ADDR_WIDTH-1:0] inSel,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic                  grant,
  output logic                  ready,
  output logic                  load,
  output logic                  bufV,
  output logic [ADDR_WIDTH-1:0] bufSel,
  output logic [DATA_WIDTH-1:0] bufData
);

  assign ready = !rst && (!bufV || grant);

  // Writes to x0 complete the handshake but are never buffered.
  assign load = inValid && ready && (inSel != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufV    <= 1'b0;
      bufSel  <= '0;
      bufData <= '0;
    end else if (load) begin
      bufV    <= 1'b1;
      bufSel  <= inSel;
      bufData <= inData;
    end else if (grant) begin
      bufV    <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two producers share the regfile write port.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : wb_arbiter_if.slave (handshakes, write port, hazard snoop)
// One buffered write retires per cycle, oldest first; simultaneous arrivals
// are resolved by a round-robin bit that flips after each tie.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int ADDR_WIDTH = addrWidth(REG_COUNT);

  logic [NUM_WB_REQ-1:0]                 bufV;
  logic [NUM_WB_REQ-1:0]                 load;
  logic [NUM_WB_REQ-1:0]                 grant;
  logic [NUM_WB_REQ-1:0]                 ready;
  logic [NUM_WB_REQ-1:0]                 nextV;
  logic [NUM_WB_REQ-1:0][ADDR_WIDTH-1:0] bufSel;
  logic [NUM_WB_REQ-1:0][DATA_WIDTH-1:0] bufData;

  logic older;  // index of the older entry when both are valid
  logic tie;    // both entries were loaded at the same edge
  logic rr;     // tie winner

  for (genvar i = 0; i < NUM_WB_REQ; i++) begin : g_slot
    wb_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .inValid (bus.req_valid[i]),
      .inSel   (bus.req_sel[i]),
      .inData  (bus.req_data[i]),
      .grant   (grant[i]),
      .ready   (ready[i]),
      .load    (load[i]),
      .bufV    (bufV[i]),
      .bufSel  (bufSel[i]),
      .bufData (bufData[i])
    );
  end

  assign bus.req_ready = ready;

  // Grant depends only on registered state, so req_* never reaches wen.
  always_comb begin
    grant = '0;
    case (bufV)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (tie ? rr : older) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  assign bus.wen      = |grant;
  assign bus.regW_sel = grant[1] ? bufSel[1]  : (grant[0] ? bufSel[0]  : '0);
  assign bus.regW_i   = grant[1] ? bufData[1] : (grant[0] ? bufData[0] : '0);

  assign nextV = load | (bufV & ~grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older <= 1'b0;
      tie   <= 1'b0;
      rr    <= 1'b0;
    end else begin
      // A tie is always resolved by exactly one grant while both are valid.
      if ((&bufV) && tie) rr <= ~rr;

      if (&load) begin
        tie <= 1'b1;
      end else if (load[0] && nextV[1]) begin
        older <= 1'b1;
        tie   <= 1'b0;
      end else if (load[1] && nextV[0]) begin
        older <= 1'b0;
        tie   <= 1'b0;
      end else if (!(&nextV)) begin
        tie <= 1'b0;
      end
    end
  end

  logic hazA;
  logic hazB;

  always_comb begin
    hazA = 1'b0;
    hazB = 1'b0;
    for (int i = 0; i < NUM_WB_REQ; i++) begin
      if (bufV[i] && bufSel[i] == bus.regA_sel && bus.regA_sel != '0) hazA = 1'b1;
      if (bufV[i] && bufSel[i] == bus.regB_sel && bus.regB_sel != '0) hazB = 1'b1;
    end
  end

  assign bus.hazard_a = hazA;
  assign bus.hazard_b = hazB;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DW = 32;
  localparam int RC = 32;
  localparam int AW = addrWidth(RC);

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wb_arbiter #(.DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Regfile written by the DUT's write port.
  logic [DW-1:0] rf [RC];
  logic [DW-1:0] rdA, rdB;
  assign rdA = rf[bus.regA_sel];
  assign rdB = rf[bus.regB_sel];
  always @(posedge clk) if (bus.wen === 1'b1) rf[bus.regW_sel] <= bus.regW_i;

  // Reference model: each buffer holds an entry stamped with its arrival
  // cycle; the earliest stamp retires first, equal stamps alternate.
  typedef struct {
    bit            v;
    logic [AW-1:0] sel;
    logic [DW-1:0] data;
    int            stamp;
  } ent_t;

  ent_t          ent [2];
  int            tieCnt = 0;
  int            cyc    = 0;
  logic [DW-1:0] refRegs [RC];
  wb_req_t       expQ [$];

  task automatic modelStep();
    int       g;
    logic [1:0] rdy;
    logic     expHa, expHb;
    if (rst) begin
      for (int i = 0; i < 2; i++) ent[i].v = 0;
      tieCnt = 0;
      check("rst_wen", bus.wen, 0);
      check("rst_ready", bus.req_ready, 0);
      check("rst_regW_sel", bus.regW_sel, 0);
      check("rst_regW_i", bus.regW_i, 0);
      check("rst_hazard", {bus.hazard_a, bus.hazard_b}, 0);
    end else begin
      g = -1;
      if (ent[0].v && ent[1].v) begin
        if (ent[0].stamp < ent[1].stamp) g = 0;
        else if (ent[0].stamp > ent[1].stamp) g = 1;
        else begin
          g = tieCnt % 2;
          tieCnt++;
        end
      end else if (ent[0].v) g = 0;
      else if (ent[1].v) g = 1;

      check("wen", bus.wen, (g >= 0));
      if (g >= 0) begin
        wb_req_t it;
        it.sel  = ent[g].sel;
        it.data = ent[g].data;
        expQ.push_back(it);
        refRegs[ent[g].sel] = ent[g].data;
      end

      expHa = 0;
      expHb = 0;
      for (int i = 0; i < 2; i++) begin
        if (ent[i].v && ent[i].sel == bus.regA_sel && bus.regA_sel != 0) expHa = 1;
        if (ent[i].v && ent[i].sel == bus.regB_sel && bus.regB_sel != 0) expHb = 1;
      end
      check("hazard_a", bus.hazard_a, expHa);
      check("hazard_b", bus.hazard_b, expHb);

      for (int i = 0; i < 2; i++) rdy[i] = !ent[i].v || (g == i);
      check("req_ready", bus.req_ready, rdy);

      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && rdy[i] && bus.req_sel[i] != 0) begin
          ent[i].v     = 1;
          ent[i].sel   = bus.req_sel[i];
          ent[i].data  = bus.req_data[i];
          ent[i].stamp = cyc;
        end else if (g == i) begin
          ent[i].v = 0;
        end
      end
      cyc++;
    end
  endtask

  always @(negedge clk) begin
    #2;
    modelStep();
  end

  // Monitor: every write the DUT presents is matched against the scoreboard.
  int            wenPulses  = 0;
  int            hazACycles = 0;
  logic [AW-1:0] wrLog [$];

  always @(negedge clk) begin
    #3;
    if (bus.wen === 1'b1) begin
      wenPulses++;
      wrLog.push_back(bus.regW_sel);
      if (expQ.size() == 0) begin
        check("spurious_write", bus.wen, 0);
      end else begin
        wb_req_t e;
        e = expQ.pop_front();
        check("regW_sel", bus.regW_sel, e.sel);
        check("regW_i", bus.regW_i, e.data);
      end
    end
    if (bus.hazard_a === 1'b1) hazACycles++;
  end

  // Stimulus
  wb_req_t q0 [$];
  wb_req_t q1 [$];
  bit      randSnoop = 0;

  task automatic snoop();
    if (randSnoop) begin
      bus.regA_sel = AW'($urandom_range(0, RC - 1));
      bus.regB_sel = AW'($urandom_range(0, RC - 1));
    end
  endtask

  task automatic runItems(input int maxCycles, output int used);
    used = 0;
    while (q0.size() != 0 || q1.size() != 0) begin
      @(negedge clk);
      if (used >= maxCycles) begin
        check("driver_timeout", q0.size() + q1.size(), 0);
        q0.delete();
        q1.delete();
        break;
      end
      bus.req_valid[0] = (q0.size() != 0);
      bus.req_valid[1] = (q1.size() != 0);
      if (q0.size() != 0) begin
        bus.req_sel[0]  = q0[0].sel;
        bus.req_data[0] = q0[0].data;
      end
      if (q1.size() != 0) begin
        bus.req_sel[1]  = q1[0].sel;
        bus.req_data[1] = q1[0].data;
      end
      snoop();
      used++;
      #1;
      if (bus.req_valid[0] && bus.req_ready[0] === 1'b1) void'(q0.pop_front());
      if (bus.req_valid[1] && bus.req_ready[1] === 1'b1) void'(q1.pop_front());
    end
    @(negedge clk);
    bus.req_valid = '0;
    snoop();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.req_valid = '0;
      snoop();
    end
  endtask

  function automatic wb_req_t mk(input int sel, input logic [DW-1:0] data);
    wb_req_t it;
    it.sel  = AW'(sel);
    it.data = data;
    return it;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.req_data  = '0;
    bus.regA_sel  = '0;
    bus.regB_sel  = '0;
    for (int r = 0; r < RC; r++) begin
      rf[r]      = '0;
      refRegs[r] = '0;
    end
    for (int i = 0; i < 2; i++) ent[i].v = 0;

    #1;
    check("init_wen", bus.wen, 0);
    check("init_regW_sel", bus.regW_sel, 0);
    check("init_regW_i", bus.regW_i, 0);
    check("init_ready", bus.req_ready, 0);
    check("init_hazard", {bus.hazard_a, bus.hazard_b}, 0);
    #22 rst = 1'b0;

    // Single write
    bus.regA_sel = AW'(5);
    hazACycles = 0;
    q0.push_back(mk(5, 32'hDEADBEEF));
    runItems(10, used);
    idle(3);
    check("single_hazard_cycles", hazACycles, 1);
    check("single_rf_r5", rdA, 32'hDEADBEEF);

    // x0 drop
    bus.regA_sel = '0;
    wenPulses = 0;
    q1.push_back(mk(0, 32'h12345678));
    runItems(10, used);
    check("x0_handshake_cycles", used, 1);
    idle(3);
    check("x0_no_write", wenPulses, 0);

    // Two ties in a row
    wrLog.delete();
    q0.push_back(mk(3, 32'hA0000003));
    q1.push_back(mk(4, 32'hB0000004));
    runItems(10, used);
    idle(3);
    q0.push_back(mk(3, 32'hA1000003));
    q1.push_back(mk(4, 32'hB1000004));
    runItems(10, used);
    idle(3);
    check("tie_write_count", wrLog.size(), 4);
    if (wrLog.size() == 4) begin
      check("tie1_first", wrLog[0], 3);
      check("tie1_second", wrLog[1], 4);
      check("tie2_first", wrLog[2], 4);
      check("tie2_second", wrLog[3], 3);
    end

    // Same-register ordering
    wrLog.delete();
    q0.push_back(mk(13, 32'h0000_0D0D));
    q0.push_back(mk(7, 32'd1));
    q1.push_back(mk(14, 32'h0000_0E0E));
    q1.push_back(mk(7, 32'd2));
    runItems(10, used);
    idle(4);
    check("order_write_count", wrLog.size(), 4);
    if (wrLog.size() == 4) begin
      check("order_w0", wrLog[0], 13);
      check("order_w1", wrLog[1], 14);
      check("order_w2", wrLog[2], 7);
      check("order_w3", wrLog[3], 7);
    end
    @(negedge clk);
    bus.regA_sel = AW'(7);
    #1;
    check("order_r7", rdA, 32'd2);

    // Both streaming
    randSnoop = 1;
    wenPulses = 0;
    for (int k = 0; k < 20; k++) begin
      q0.push_back(mk($urandom_range(1, RC - 1), $urandom));
      q1.push_back(mk($urandom_range(1, RC - 1), $urandom));
    end
    runItems(80, used);
    check("stream_handoff_cycles", used, 39);
    idle(4);
    check("stream_wen_pulses", wenPulses, 40);

    // Reset mid-stream with both buffers full
    for (int k = 0; k < 10; k++) begin
      q0.push_back(mk($urandom_range(1, RC - 1), $urandom));
      q1.push_back(mk($urandom_range(1, RC - 1), $urandom));
    end
    fork
      runItems(80, used);
      begin
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_wen", bus.wen, 0);
        check("async_rst_regW_sel", bus.regW_sel, 0);
        check("async_rst_regW_i", bus.regW_i, 0);
        check("async_rst_hazard", {bus.hazard_a, bus.hazard_b}, 0);
        check("async_rst_ready", bus.req_ready, 0);
        @(posedge clk);
        #4 rst = 1'b0;
        #1;
        check("post_rst_ready", bus.req_ready, 2'b11);
      end
    join
    idle(4);

    // Regfile against the reference model
    randSnoop = 0;
    for (int r = 0; r < RC; r++) begin
      @(negedge clk);
      bus.regA_sel = AW'(r);
      bus.regB_sel = AW'(RC - 1 - r);
      #1;
      check("rf_read_a", rdA, refRegs[r]);
      check("rf_read_b", rdB, refRegs[RC - 1 - r]);
    end
    idle(2);
    check("scoreboard_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
